hangman_game_ctrl: RTL

- Game-level sequencer between the keypad letter-entry FSM and the UART transmit side.
- Holds the secret word and checks each submitted ASCII letter against it, one position per cycle.
- Tracks revealed positions, letters already used and the miss count.
- Reports every accepted guess over a valid/ready byte port and declares win or lose.

---
 rtl/hangman_pkg.sv | 24 ++
 rtl/hangman_game_ctrl_tx.sv | 28 ++
 rtl/hangman_game_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game controller.
// States, ASCII constants and a small character-class helper.
package hangman_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAY        = 3'd1,
    CHECK       = 3'd2,
    REPORT      = 3'd3,
    REPORT_STAT = 3'd4,
    WIN         = 3'd5,
    LOSE        = 3'd6
  } game_state_t;

  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_Z    = 8'h5A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] LOWER_MASK = 8'h20;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_tx.sv
// Transmit byte register for the hangman controller.
// Holds tx_data/tx_valid until the sink accepts; flush drops a pending byte.
module hangman_tx_port (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       flush,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= 8'h00;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Hangman game sequencer: checks guesses, tracks progress, reports bytes.
// Define HANGMAN_STATUS_BYTE_EN to send a miss-count byte after each report.
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int WORD_LEN   = 5,
  parameter int MAX_MISSES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  word_load,
  input  logic [8*WORD_LEN-1:0] word_in,
  input  logic                  guess_valid,
  input  logic [7:0]            guess_char,
  input  logic                  game_end_req,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [3:0]            miss_count,
  output logic [2:0]            state,
  output logic                  win,
  output logic                  lose,
  output logic                  guess_dup
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [3:0] MISS_MAX = 4'(MAX_MISSES);

  game_state_t cur_state, nxt_state, end_state;

  logic [8*WORD_LEN-1:0] word;
  logic [25:0]           used;
  logic [7:0]            chr;
  logic                  hit;
  logic [IDX_W-1:0]      idx;

  logic       is_letter;
  logic [4:0] letter_idx;
  logic       letter_used;
  logic       match;
  logic       last;
  logic       hit_now;
  logic       xfer;
  logic       tx_load;
  logic [7:0] tx_byte;

  assign is_letter   = is_upper(guess_char);
  assign letter_idx  = guess_char[4:0] - 5'd1;
  assign letter_used = used[letter_idx];
  assign match       = (word[idx*8 +: 8] == chr);
  assign last        = (idx == LAST_IDX);
  assign hit_now     = hit | match;
  assign xfer        = tx_valid & tx_ready;

  // Outcome of a finished report, from the already-updated score.
  assign end_state = (&revealed)              ? WIN  :
                     (miss_count == MISS_MAX) ? LOSE : PLAY;

  always_ff @(posedge clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    tx_load   = 1'b0;
    tx_byte   = 8'h00;
    if (game_end_req) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE, WIN, LOSE: begin
          if (word_load) nxt_state = PLAY;
        end
        PLAY: begin
          if (guess_valid && is_letter && !letter_used)
            nxt_state = CHECK;
        end
        CHECK: begin
          if (last) begin
            nxt_state = REPORT;
            tx_load   = 1'b1;
            tx_byte   = hit_now ? chr : (chr | LOWER_MASK);
          end
        end
        REPORT: begin
          if (xfer) begin
`ifdef HANGMAN_STATUS_BYTE_EN
            nxt_state = REPORT_STAT;
            tx_load   = 1'b1;
            tx_byte   = ASCII_ZERO + {4'h0, miss_count};
`else
            nxt_state = end_state;
`endif
          end
        end
`ifdef HANGMAN_STATUS_BYTE_EN
        REPORT_STAT: begin
          if (xfer) nxt_state = end_state;
        end
`endif
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word       <= '0;
      revealed   <= '0;
      miss_count <= 4'd0;
      used       <= '0;
      chr        <= 8'h00;
      hit        <= 1'b0;
      idx        <= '0;
      guess_dup  <= 1'b0;
    end else begin
      guess_dup <= 1'b0;
      if (game_end_req) begin
        revealed   <= '0;
        miss_count <= 4'd0;
        used       <= '0;
      end else begin
        case (cur_state)
          IDLE, WIN, LOSE: begin
            if (word_load) begin
              word       <= word_in;
              revealed   <= '0;
              miss_count <= 4'd0;
              used       <= '0;
            end
          end
          PLAY: begin
            if (guess_valid && is_letter) begin
              if (letter_used) begin
                guess_dup <= 1'b1;
              end else begin
                used[letter_idx] <= 1'b1;
                chr              <= guess_char;
                hit              <= 1'b0;
                idx              <= '0;
              end
            end
          end
          CHECK: begin
            if (match) begin
              revealed[idx] <= 1'b1;
              hit           <= 1'b1;
            end
            if (!last) begin
              idx <= idx + 1'b1;
            end else if (!hit_now && miss_count < MISS_MAX) begin
              miss_count <= miss_count + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  hangman_tx_port u_tx (
    .clk       (clk),
    .reset     (reset),
    .load      (tx_load),
    .load_data (tx_byte),
    .flush     (game_end_req),
    .ready     (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid)
  );

  assign state = cur_state;
  assign win   = (cur_state == WIN);
  assign lose  = (cur_state == LOSE);

endmodule
